sequential_division: RTL and testbench

Multi-cycle restoring divider, the inverse of the calculator's combinational 16x16 multiplier. It takes a 2·WIDTH-bit dividend (product-sized) and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and remainder after WIDTH iterations. It sits beside the multiplier in the calculator datapath and exchanges operands and results with the middleware-facing control through a start/done handshake.

---
 rtl/calc_pkg.sv | 17 +
 rtl/sequential_division_if.sv | 29 ++
 rtl/division_step.sv | 27 ++
 rtl/sequential_division.sv | 121 ++++++++++++
 tb/tb_sequential_division.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath width, divider FSM states
// and the quotient value reported on divide error.
package calc_pkg;

    // Operand width shared by the multiplier and the divider.
    localparam int CALC_WIDTH = 16;

    // Wide enough for any supported width; sliced to WIDTH at use.
    localparam logic [63:0] ERR_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/sequential_division_if.sv
// Start/done handshake bundle between control and the divider.
// master: start, inputDividend, inputDivisor -> ; slave returns
// busy, done, quotient, remainder, error.
interface sequential_division_if
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
);

    logic                 start;
    logic [2*WIDTH-1:0]   inputDividend;
    logic [WIDTH-1:0]     inputDivisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 error;

    modport master (
        output start, inputDividend, inputDivisor,
        input  busy, done, quotient, remainder, error
    );

    modport slave (
        input  start, inputDividend, inputDivisor,
        output busy, done, quotient, remainder, error
    );

endinterface

// File: rtl/division_step.sv
// One restoring-division iteration: shift in a dividend bit, compare
// against the divisor, subtract if it fits. Ports: r, next_bit,
// divisor in; r_next, q_bit out.
module division_step
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    // Shifted remainder needs one extra bit before the compare.
    logic [WIDTH:0] r_shift;

    assign r_shift = {r, next_bit};
    assign q_bit   = (r_shift >= {1'b0, divisor});

    // After a successful subtract the result is below the divisor,
    // so truncating to WIDTH bits is lossless.
    assign r_next = q_bit ? WIDTH'(r_shift - {1'b0, divisor})
                          : r_shift[WIDTH-1:0];

endmodule

// File: rtl/sequential_division.sv
// Multi-cycle restoring divider: 2W-bit dividend / W-bit divisor in
// W iterations. Ports: clk, reset_n (sync, active low), bus (slave).
module sequential_division
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sequential_division_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state, state_n;
    // Partial remainder; the overflow pre-check keeps it in W bits.
    logic [WIDTH-1:0] r, r_n;
    logic [WIDTH-1:0] d, d_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic             err, err_n;
    logic [CW-1:0]    cnt, cnt_n;

    logic [WIDTH-1:0] step_r;
    logic             step_q;
    logic [WIDTH-1:0] hi, lo;

    assign hi = bus.inputDividend[2*WIDTH-1:WIDTH];
    assign lo = bus.inputDividend[WIDTH-1:0];

    division_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r        (r),
        .next_bit (d[WIDTH-1]),
        .divisor  (dvs),
        .r_next   (step_r),
        .q_bit    (step_q)
    );

    always_comb begin
        state_n = state;
        r_n     = r;
        d_n     = d;
        q_n     = q;
        dvs_n   = dvs;
        quo_n   = quo;
        rem_n   = rem;
        err_n   = err;
        cnt_n   = cnt;
        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (bus.start) begin
                    dvs_n = bus.inputDivisor;
                    err_n = 1'b0;
                    // High half >= divisor means the quotient
                    // would not fit in W bits.
                    if (bus.inputDivisor == '0 ||
                        hi >= bus.inputDivisor) begin
                        state_n = DONE;
                        quo_n   = ERR_QUOTIENT[WIDTH-1:0];
                        rem_n   = '0;
                        err_n   = 1'b1;
                    end else begin
                        state_n = RUN;
                        r_n     = hi;
                        d_n     = lo;
                        q_n     = '0;
                        cnt_n   = CW'(WIDTH);
                    end
                end
            end
            RUN: begin
                r_n   = step_r;
                d_n   = {d[WIDTH-2:0], 1'b0};
                q_n   = {q[WIDTH-2:0], step_q};
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    quo_n   = {q[WIDTH-2:0], step_q};
                    rem_n   = step_r;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            r     <= '0;
            d     <= '0;
            q     <= '0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            r     <= r_n;
            d     <= d_n;
            q     <= q_n;
            dvs   <= dvs_n;
            quo   <= quo_n;
            rem   <= rem_n;
            err   <= err_n;
            cnt   <= cnt_n;
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quo;
    assign bus.remainder = rem;
    assign bus.error     = err;

endmodule

// File: tb/tb_sequential_division.sv
// Self-checking bench for sequential_division: arithmetic reference
// model checked every cycle, plus directed literal cases.
module tb_sequential_division;

    localparam int W = 16;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   mon_en;

    sequential_division_if #(.WIDTH(W)) bus ();

    sequential_division #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference model: quotient/remainder from plain / and %, timing
    // from the handshake rules (W busy cycles, then one done cycle).
    logic        m_busy, m_done, m_err;
    logic [15:0] m_q, m_r, m_pq, m_pr;
    int          m_left;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy <= 0; m_done <= 0; m_err <= 0;
            m_q <= 0; m_r <= 0; m_left <= 0;
        end else if (bus.start && !m_busy) begin
            if (bus.inputDivisor == 0 ||
                bus.inputDividend[31:16] >= bus.inputDivisor) begin
                m_done <= 1; m_err <= 1; m_busy <= 0;
                m_q <= 16'hFFFF; m_r <= 0;
            end else begin
                m_busy <= 1; m_done <= 0; m_err <= 0; m_left <= W;
                m_pq <= 16'(bus.inputDividend / {16'd0, bus.inputDivisor});
                m_pr <= 16'(bus.inputDividend % {16'd0, bus.inputDivisor});
            end
        end else if (m_busy) begin
            m_left <= m_left - 1;
            m_done <= 0;
            if (m_left == 1) begin
                m_busy <= 0; m_done <= 1; m_q <= m_pq; m_r <= m_pr;
            end
        end else begin
            m_done <= 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("error", 32'(bus.error), 32'(m_err));
            check("quotient", 32'(bus.quotient), 32'(m_q));
            check("remainder", 32'(bus.remainder), 32'(m_r));
        end
    end

    // Wait for done with a bound; reports edges since the accepting edge.
    task automatic wait_done(input int a0, output int lat, output int bc);
        bit seen;
        seen = 0; lat = -1; bc = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.done) begin
                seen = 1;
                lat = cyc - a0 - 1;
            end else begin
                bc += int'(bus.busy);
                @(negedge clk);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic run_div(input logic [31:0] dd, input logic [15:0] dv,
                           output int lat, output int bc);
        int a0;
        @(negedge clk);
        a0 = cyc;
        bus.start = 1; bus.inputDividend = dd; bus.inputDivisor = dv;
        @(negedge clk);
        bus.start = 0;
        wait_done(a0, lat, bc);
    endtask

    function automatic logic [47:0] gen_ops();
        logic [15:0] dv, hi, lo;
        int m;
        m  = $urandom_range(0, 9);
        dv = 16'($urandom);
        if (m == 0) dv = 0;
        lo = 16'($urandom);
        if (m == 1 || dv == 0) hi = 16'($urandom);
        else hi = 16'($urandom_range(0, int'(dv) - 1));
        return {hi, lo, dv};
    endfunction

    initial begin
        int lat, bc, a0, c1, c2, dones;
        logic [47:0] ops;
        n_checks = 0; n_fail = 0; mon_en = 0; cyc = 0;
        reset_n = 0;
        bus.start = 0; bus.inputDividend = 0; bus.inputDivisor = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        mon_en = 1;
        check("reset_quotient", 32'(bus.quotient), 0);
        check("reset_busy", 32'(bus.busy), 0);

        run_div(32'h000186A0, 16'h012C, lat, bc);
        check("q_100000_300", 32'(bus.quotient), 333);
        check("r_100000_300", 32'(bus.remainder), 100);
        check("e_100000_300", 32'(bus.error), 0);
        check("lat_normal", lat, 16);
        check("busy_cycles", bc, 16);

        run_div(32'hFFFE0001, 16'hFFFF, lat, bc);
        check("q_roundtrip", 32'(bus.quotient), 32'hFFFF);
        check("r_roundtrip", 32'(bus.remainder), 0);

        run_div(32'd1234, 16'd0, lat, bc);
        check("e_div0", 32'(bus.error), 1);
        check("q_div0", 32'(bus.quotient), 32'hFFFF);
        check("r_div0", 32'(bus.remainder), 0);
        check("lat_div0", lat, 0);
        check("busy_div0", bc, 0);

        run_div(32'h00050000, 16'd5, lat, bc);
        check("e_ovf", 32'(bus.error), 1);
        check("q_ovf", 32'(bus.quotient), 32'hFFFF);
        check("lat_ovf", lat, 0);

        run_div(32'h00040000, 16'd5, lat, bc);
        check("q_40000_5", 32'(bus.quotient), 32'hCCCC);
        check("r_40000_5", 32'(bus.remainder), 4);
        check("e_40000_5", 32'(bus.error), 0);

        // Second start during RUN must be ignored.
        @(negedge clk);
        a0 = cyc;
        bus.start = 1; bus.inputDividend = 32'h000186A0;
        bus.inputDivisor = 16'h012C;
        @(negedge clk);
        bus.start = 0;
        repeat (4) @(negedge clk);
        bus.start = 1; bus.inputDividend = 32'h00001000;
        bus.inputDivisor = 16'h0003;
        @(negedge clk);
        bus.start = 0;
        wait_done(a0, lat, bc);
        check("q_ignored", 32'(bus.quotient), 333);
        check("r_ignored", 32'(bus.remainder), 100);
        check("lat_ignored", lat, 16);

        // Start held high through DONE: back-to-back acceptance.
        @(negedge clk);
        a0 = cyc;
        bus.start = 1; bus.inputDividend = 32'h00040000;
        bus.inputDivisor = 16'd5;
        @(negedge clk);
        wait_done(a0, lat, bc);
        c1 = cyc;
        check("q_b2b_first", 32'(bus.quotient), 32'hCCCC);
        bus.inputDividend = 32'hFFFE0001; bus.inputDivisor = 16'hFFFF;
        @(negedge clk);
        bus.start = 0;
        wait_done(c1 - 1, lat, bc);
        c2 = cyc;
        check("b2b_spacing", c2 - c1, 17);
        check("q_b2b_second", 32'(bus.quotient), 32'hFFFF);

        // Reset in the middle of RUN.
        @(negedge clk);
        bus.start = 1; bus.inputDividend = 32'h000186A0;
        bus.inputDivisor = 16'h012C;
        @(negedge clk);
        bus.start = 0;
        dones = 0;
        repeat (7) begin
            dones += int'(bus.done);
            @(negedge clk);
        end
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_q", 32'(bus.quotient), 0);
        check("rst_r", 32'(bus.remainder), 0);
        check("rst_no_done", dones, 0);
        run_div(32'h00040000, 16'd5, lat, bc);
        check("q_after_rst", 32'(bus.quotient), 32'hCCCC);
        check("lat_after_rst", lat, 16);

        // Random traffic, including starts during RUN and rare resets.
        dones = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            dones += int'(bus.done);
            ops = gen_ops();
            bus.start = ($urandom_range(0, 3) == 0);
            bus.inputDividend = ops[47:16];
            bus.inputDivisor = ops[15:0];
            reset_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        bus.start = 0;
        reset_n = 1;
        repeat (20) @(negedge clk);
        if (dones < 50) check("random_done_count", dones, 50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
